// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the integer ALU through a 2-entry skid buffer.
// Optional writeback bypass on the register operands: define ALU_ISSUE_BYPASS_EN.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand1,
  output logic [XLEN-1:0] out_operand2,
  output logic [2:0]      out_funct3,
  output logic            out_subsra,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  input  logic            byp_valid,
  input  logic [RD_W-1:0] byp_rd,
  input  logic [XLEN-1:0] byp_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [2:0]      funct3;
    logic            subsra;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd3
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, dec;
  logic   load_main, load_skid, skid_to_main;
  logic   in_fire, out_fire;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_val;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign imm_val = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  logic byp_rs1_hit, byp_rs2_hit;
  assign byp_rs1_hit = byp_valid && (byp_rd != '0) && (byp_rd == RD_W'(in_instr[19:15]));
  assign byp_rs2_hit = byp_valid && (byp_rd != '0) && (byp_rd == RD_W'(in_instr[24:20]));
  assign rs1_val     = byp_rs1_hit ? byp_data : in_rs1_data;
  assign rs2_val     = byp_rs2_hit ? byp_data : in_rs2_data;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_valid, byp_rd, byp_data, in_instr[19:15]};
  assign rs1_val    = in_rs1_data;
  assign rs2_val    = in_rs2_data;
`endif

  // Decode into an entry; illegal encodings keep only rd so the ALU sees a benign op.
  always_comb begin
    logic            legal;
    logic            subsra;
    logic [XLEN-1:0] op2;
    legal  = 1'b0;
    subsra = 1'b0;
    op2    = '0;
    dec    = '0;
    unique case (opcode)
      OPC_OP: begin
        legal  = (funct7 == F7_ZERO) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        op2    = rs2_val;
        subsra = in_instr[30];
      end
      OPC_OP_IMM: begin
        op2 = imm_val;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          legal  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          subsra = in_instr[30];
        end else begin
          legal = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    dec.rd = RD_W'(in_instr[11:7]);
    if (legal) begin
      dec.operand1 = rs1_val;
      dec.operand2 = op2;
      dec.funct3   = funct3;
      dec.subsra   = subsra;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != ST_FULL);
      out_valid <= (state_d != ST_EMPTY);
    end
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Buffer write controls.
  always_comb begin
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: load_main = in_fire;
        ST_ONE: begin
          load_main = in_fire && out_fire;
          load_skid = in_fire && !out_fire;
        end
        ST_FULL: begin
          load_main    = out_fire;
          skid_to_main = out_fire;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= skid_to_main ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  assign out_operand1 = main_q.operand1;
  assign out_operand2 = main_q.operand2;
  assign out_funct3   = main_q.funct3;
  assign out_subsra   = main_q.subsra;
  assign out_rd       = main_q.rd;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, skid back-pressure, flush, reset, bypass.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic [31:0] out_operand1, out_operand2, byp_data;
  logic [2:0]  out_funct3;
  logic        out_subsra, out_illegal, byp_valid;
  logic [4:0]  out_rd, byp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_funct3(out_funct3), .out_subsra(out_subsra), .out_rd(out_rd),
    .out_illegal(out_illegal),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                            input logic [2:0] f3, input logic sub, input logic [4:0] rd,
                            input logic ill);
    check({tag, ".valid"},   32'(out_valid),    32'd1);
    check({tag, ".op1"},     out_operand1,      op1);
    check({tag, ".op2"},     out_operand2,      op2);
    check({tag, ".funct3"},  32'(out_funct3),   32'(f3));
    check({tag, ".subsra"},  32'(out_subsra),   32'(sub));
    check({tag, ".rd"},      32'(out_rd),       32'(rd));
    check({tag, ".illegal"}, 32'(out_illegal),  32'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    drive(instr, rs1, rs2);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
    byp_valid = 1'b0; byp_rd = '0; byp_data = '0;
    #12;
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.ready", 32'(in_ready),  32'd1);
    check("reset.op1",   out_operand1,   32'd0);
    check("reset.rd",    32'(out_rd),    32'd0);
    rst_n = 1'b1;
    tick();

    // Decode, streaming with out_ready high
    send(32'h402080B3, 32'd10, 32'd3);
    expect_out("sub", 32'd10, 32'd3, 3'b000, 1'b1, 5'd1, 1'b0);
    send(32'h4050D093, 32'h80, 32'd77);
    check("srai.op1",    out_operand1,          32'h80);
    check("srai.shamt",  32'(out_operand2[4:0]), 32'd5);
    check("srai.funct3", 32'(out_funct3),       32'd5);
    check("srai.subsra", 32'(out_subsra),       32'd1);
    check("srai.ill",    32'(out_illegal),      32'd0);
    send(32'hFFF00193, 32'd7, 32'd99);
    expect_out("addi", 32'd7, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd3, 1'b0);
    send(32'h0000A283, 32'd11, 32'd12);
    expect_out("load", 32'd0, 32'd0, 3'b000, 1'b0, 5'd5, 1'b1);
    send(32'h4020E1B3, 32'd11, 32'd12);
    expect_out("op_bad", 32'd0, 32'd0, 3'b000, 1'b0, 5'd3, 1'b1);
    send(32'h40109093, 32'd11, 32'd12);
    expect_out("slli_bad", 32'd0, 32'd0, 3'b000, 1'b0, 5'd1, 1'b1);
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Back-pressure: A, B fill the buffer, C is stalled
    out_ready = 1'b0;
    drive(32'h00208233, 32'd1, 32'd2); tick();
    check("bp1.ready", 32'(in_ready), 32'd1);
    drive(32'h0020C333, 32'd5, 32'd6); tick();
    check("bp2.ready", 32'(in_ready), 32'd0);
    check("bp2.rd",    32'(out_rd),   32'd4);
    drive(32'h0020E3B3, 32'd9, 32'd10); tick();
    check("bp3.ready", 32'(in_ready), 32'd0);
    expect_out("bp3.hold", 32'd1, 32'd2, 3'b000, 1'b0, 5'd4, 1'b0);
    out_ready = 1'b1; tick();
    expect_out("bp.B", 32'd5, 32'd6, 3'b100, 1'b0, 5'd6, 1'b0);
    check("bp.B.ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_out("bp.C", 32'd9, 32'd10, 3'b110, 1'b0, 5'd7, 1'b0);
    tick();
    check("bp.end.valid", 32'(out_valid), 32'd0);

    // Flush while FULL, and flush in ONE with a concurrent transfer
    out_ready = 1'b0;
    send(32'h00208233, 32'd1, 32'd2);
    send(32'h0020C333, 32'd5, 32'd6);
    check("fl.full.ready", 32'(in_ready), 32'd0);
    flush = 1'b1; drive(32'h0020E3B3, 32'd9, 32'd10); tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.full.valid", 32'(out_valid), 32'd0);
    check("fl.full.ready2", 32'(in_ready), 32'd1);
    send(32'h00208233, 32'd1, 32'd2);
    flush = 1'b1; drive(32'h0020E3B3, 32'd9, 32'd10); tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.one.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1; tick();
    check("fl.after.valid", 32'(out_valid), 32'd0);
    check("fl.after.ready", 32'(in_ready),  32'd1);

    // Asynchronous reset while an entry is valid
    out_ready = 1'b0;
    send(32'h0020C333, 32'd5, 32'd6);
    check("rst.pre.valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.mid.valid", 32'(out_valid),  32'd0);
    check("rst.mid.ready", 32'(in_ready),   32'd1);
    check("rst.mid.op1",   out_operand1,    32'd0);
    check("rst.mid.rd",    32'(out_rd),     32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst.post.valid", 32'(out_valid), 32'd0);

    // Writeback bypass
    byp_valid = 1'b1; byp_rd = 5'd5; byp_data = 32'h1234;
    send(32'h00228233, 32'h11, 32'h22);
`ifdef ALU_ISSUE_BYPASS_EN
    check("byp.rs1", out_operand1, 32'h1234);
`else
    check("byp.rs1", out_operand1, 32'h11);
`endif
    check("byp.rs1.op2", out_operand2, 32'h22);
    send(32'h00508233, 32'h11, 32'h22);
    check("byp.rs2.op1", out_operand1, 32'h11);
`ifdef ALU_ISSUE_BYPASS_EN
    check("byp.rs2", out_operand2, 32'h1234);
`else
    check("byp.rs2", out_operand2, 32'h22);
`endif
    byp_rd = 5'd0;
    send(32'h00200233, 32'h33, 32'h44);
    check("byp.x0.op1", out_operand1, 32'h33);
    byp_rd = 5'd31;
    send(32'hFFF00193, 32'h55, 32'h66);
    check("byp.imm.op2", out_operand2, 32'hFFFFFFFF);
    byp_valid = 1'b0; byp_rd = 5'd5;
    send(32'h00228233, 32'h77, 32'h22);
    check("byp.off.op1", out_operand1, 32'h77);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
